// File: rtl/io_bus_arbiter.sv
// Two-master single-word arbiter for the shared memory-mapped I/O bus.
// Define IO_ARB_FIXED_PRIO_EN to make m0 always win ties (default: round-robin).
module io_bus_arbiter #(
    parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_datain,
    output logic        bus_en,
    input  logic [31:0] bus_dataout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        ACK  = 2'd3
    } state_t;

    state_t state, state_nx;
    logic   last, last_nx;   // 1 = m1 was granted most recently
    logic   pick0;

    always_comb begin
        state_nx   = state;
        last_nx    = last;
        pick0      = 1'b0;
        bus_addr   = IDLE_ADDR;
        bus_datain = '0;
        bus_en     = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) begin
`ifdef IO_ARB_FIXED_PRIO_EN
                    pick0 = 1'b1;
`else
                    pick0 = last;
`endif
                end else begin
                    pick0 = m0_req;
                end
                if (m0_req || m1_req) begin
                    state_nx = pick0 ? GNT0 : GNT1;
                    last_nx  = ~pick0;
                end
            end
            GNT0: begin
                bus_addr   = m0_addr;
                bus_datain = m0_wdata;
                bus_en     = m0_we;
                state_nx   = ACK;
            end
            GNT1: begin
                bus_addr   = m1_addr;
                bus_datain = m1_wdata;
                bus_en     = m1_we;
                state_nx   = ACK;
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Acks and read data are registered at the edge closing the grant cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            state  <= state_nx;
            last   <= last_nx;
            m0_ack <= (state == GNT0);
            m1_ack <= (state == GNT1);
            if (state == GNT0) m0_rdata <= bus_dataout;
            if (state == GNT1) m1_rdata <= bus_dataout;
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: per-cycle model comparison plus
// directed scenarios with literal expectations.
module tb_io_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] bus_addr, bus_datain, bus_dataout;
    logic        bus_en;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_cnt = 0, act_cnt = 0, kbd_cnt = 0;
    logic [31:0] act_addr = '0;

    io_bus_arbiter #(.IDLE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .bus_addr(bus_addr), .bus_datain(bus_datain), .bus_en(bus_en),
        .bus_dataout(bus_dataout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0070_0000) return 32'h1234_5678;
        return a ^ 32'h5A5A_A5A5;
    endfunction

    assign bus_dataout = mem_fn(bus_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: an access owns the bus for one cycle, then acks for one cycle.
    int          mbusy = 0;   // 2 = bus cycle pending, 1 = ack cycle, 0 = free
    int          mown = 0;
    bit          mlast = 1'b1;
    logic [31:0] mrd[2] = '{32'h0, 32'h0};
    bit          mack[2] = '{1'b0, 1'b0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mbusy = 0; mlast = 1'b1;
            mrd[0] = '0; mrd[1] = '0; mack[0] = 1'b0; mack[1] = 1'b0;
        end else begin
            mack[0] = 1'b0; mack[1] = 1'b0;
            if (mbusy == 2) begin
                mrd[mown]  = mem_fn(mown == 1 ? m1_addr : m0_addr);
                mack[mown] = 1'b1;
                mbusy = 1;
            end else if (mbusy == 1) begin
                mbusy = 0;
            end else if (m0_req || m1_req) begin
                if (m0_req && m1_req) begin
`ifdef IO_ARB_FIXED_PRIO_EN
                    mown = 0;
`else
                    mown = mlast ? 0 : 1;
`endif
                end else begin
                    mown = m0_req ? 0 : 1;
                end
                mlast = (mown == 1);
                mbusy = 2;
            end
        end
    end

    logic [31:0] ea, ed;
    logic        ee;
    always @(negedge clk) begin
        if (mbusy == 2) begin
            ea = (mown == 1) ? m1_addr  : m0_addr;
            ed = (mown == 1) ? m1_wdata : m0_wdata;
            ee = (mown == 1) ? m1_we    : m0_we;
        end else begin
            ea = 32'h0; ed = 32'h0; ee = 1'b0;
        end
        chk("bus_addr",   bus_addr,   ea);
        chk("bus_datain", bus_datain, ed);
        chk("bus_en",     32'(bus_en), 32'(ee));
        chk("m0_ack",     32'(m0_ack), 32'(mack[0]));
        chk("m1_ack",     32'(m1_ack), 32'(mack[1]));
        chk("m0_rdata",   m0_rdata,   mrd[0]);
        chk("m1_rdata",   m1_rdata,   mrd[1]);
    end

    always @(negedge clk) begin
        if (bus_en) en_cnt++;
        if (bus_addr != 32'h0) begin act_cnt++; act_addr = bus_addr; end
        if (bus_addr[31:20] == 12'h003) kbd_cnt++;
    end

    task automatic clr_cnt();
        en_cnt = 0; act_cnt = 0; kbd_cnt = 0; act_addr = '0;
    endtask

    task automatic access(input int m, input logic [31:0] a, input logic [31:0] d,
                          input logic w, output int lat);
        int n;
        bit got;
        got = 1'b0;
        lat = -1;
        @(posedge clk); #2;
        if (m == 0) begin m0_addr = a; m0_wdata = d; m0_we = w; m0_req = 1'b1; end
        else        begin m1_addr = a; m1_wdata = d; m1_we = w; m1_req = 1'b1; end
        n = cyc;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((m == 0) ? m0_ack : m1_ack) begin got = 1'b1; lat = cyc - n; end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_timeout m%0d: got no ack expected ack within 20 cycles", m);
        end
        @(posedge clk); #2;
        m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    endtask

    task automatic tie_test(input string tag);
        int n;
        int own_q[$];
        int cyc_q[$];
        int exp_own[4];
`ifdef IO_ARB_FIXED_PRIO_EN
        exp_own = '{0, 0, 0, 0};
`else
        exp_own = '{0, 1, 0, 1};
`endif
        @(posedge clk); #2;
        m0_addr = 32'h0010_0000; m0_we = 1'b0; m0_req = 1'b1;
        m1_addr = 32'h0010_0004; m1_we = 1'b0; m1_req = 1'b1;
        n = cyc;
        repeat (12) @(negedge clk) begin
            if (m0_ack) begin own_q.push_back(0); cyc_q.push_back(cyc - n); end
            if (m1_ack) begin own_q.push_back(1); cyc_q.push_back(cyc - n); end
        end
        chk({tag, "_ack_count"}, 32'(own_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < own_q.size()) begin
                chk({tag, "_owner"}, own_q[i], exp_own[i]);
                chk({tag, "_ack_cycle"}, cyc_q[i], 2 + 3 * i);
            end
        end
        @(posedge clk); #2;
        m0_req = 1'b0; m1_req = 1'b0;
    endtask

    initial begin
        int lat;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_m0_ack",   32'(m0_ack), 32'd0);
        chk("rst_m1_ack",   32'(m1_ack), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_en",   32'(bus_en), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        tie_test("tie_after_reset");

        clr_cnt();
        access(0, 32'h0070_0000, 32'h0, 1'b0, lat);
        chk("rd_latency", lat, 2);
        chk("rd_data", m0_rdata, 32'h1234_5678);
        chk("rd_bus_en_cycles", en_cnt, 0);
        chk("rd_bus_cycles", act_cnt, 1);

        clr_cnt();
        access(1, 32'h0020_0010, 32'h0000_0041, 1'b1, lat);
        chk("wr_latency", lat, 2);
        chk("wr_bus_en_cycles", en_cnt, 1);
        chk("wr_bus_addr", act_addr, 32'h0020_0010);

        clr_cnt();
        access(0, 32'h0030_0000, 32'h0, 1'b0, lat);
        chk("kbd_region_cycles", kbd_cnt, 1);
        chk("kbd_data", m0_rdata, 32'h5A6A_A5A5);

        // Reset while m1 holds the bus for a write.
        @(posedge clk); #2;
        m1_addr = 32'h0020_0020; m1_wdata = 32'h77; m1_we = 1'b1; m1_req = 1'b1;
        @(posedge clk); #1;
        chk("gnt1_bus_en", 32'(bus_en), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_bus_en",   32'(bus_en), 32'd0);
        chk("midrst_m1_ack",   32'(m1_ack), 32'd0);
        chk("midrst_bus_addr", bus_addr, 32'h0);
        m1_req = 1'b0; m1_we = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        tie_test("tie_after_midrst");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Two-master arbiter for the shared memory-mapped I/O bus that feeds the address decoder. The decoder selects data memory, VGA text, offset, colour and cursor registers, the keyboard and the timer. Master 0 is the CPU load/store port; master 1 is the console engine (scroll/clear/cursor updates). The arbiter serialises single-word accesses from both masters onto the bus. It returns registered read data and a one-cycle acknowledge to the winning master.

## Interface
- `IDLE_ADDR`, default 32'h0000_0000: address driven on the bus when no master is granted. It must decode to no I/O region, so that no keyboard read strobe can fire.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `m0_req`, `m1_req`  in  1  access request; held high, with address/data/we stable, until the corresponding ack.
- `m0_addr`, `m1_addr`  in  32  access address.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  32  read data, valid while the corresponding ack is high; held afterwards.
- `bus_addr`  out  32  shared bus address.
- `bus_datain`  out  32  shared bus write data.
- `bus_en`  out  1  shared bus write enable.
- `bus_dataout`  in  32  shared bus read data; combinational from the addressed target.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - GNT0 / GNT1: access cycle for the named master.
  - ACK: completion cycle.
- IDLE:
  - No request: stay in IDLE.
  - One request: go to GNTx for that master.
  - Both requesting: winner per the arbitration policy (see Configuration).
- GNTx, exactly one cycle:
  - `bus_addr` = mx_addr.
  - `bus_datain` = mx_wdata.
  - `bus_en` = mx_we.
  - At the closing edge: capture `bus_dataout` into mx_rdata, set mx_ack, go to ACK.
- ACK, exactly one cycle:
  - mx_ack is high.
  - The bus is idle.
  - Next state is IDLE.
  - Requests sampled in ACK are ignored; the acked master may still show req high in this cycle.
- Bus idle (IDLE and ACK states):
  - `bus_addr` = IDLE_ADDR.
  - `bus_en` = 0.
  - `bus_datain` = 0.
- A read is presented to the bus for exactly one cycle, so side-effecting reads (the keyboard pop) occur exactly once per access.
- Round-robin pointer `last`, 1 bit:
  - Records the most recently granted master.
  - Updated on entry to GNTx.
- A request dropped before its ack is a protocol violation. The arbiter completes any access already in GNTx regardless.

## Timing
- Reset values:
  - State IDLE; `last` = 1, so m0 wins the first tie.
  - All acks 0; all rdata 0.
  - `bus_addr` = IDLE_ADDR; `bus_en` = 0; `bus_datain` = 0.
- Latency on an idle arbiter:
  - req rises in cycle N (sampled by the edge ending cycle N).
  - GNT in cycle N+1.
  - ack high in cycle N+2.
- Minimum access period per master: 3 cycles (GNT, ACK, IDLE).
- Both masters continuously requesting in round-robin mode: grants alternate, one grant every 3 cycles.
- Reset asserted mid-GNT:
  - Bus outputs go idle immediately (asynchronously).
  - No ack is issued.
  - The write may or may not have landed; masters must reissue.

## Configuration
- `IO_ARB_FIXED_PRIO_EN` defined: on a tie in IDLE, m0 always wins; `last` is still updated but ignored; m1 can starve.
- `IO_ARB_FIXED_PRIO_EN` undefined (default): on a tie, the master not equal to `last` wins (round-robin).

## Test plan
- Single read, m0: addr 32'h0070_0000, bus_dataout 32'h1234_5678 → `bus_en` 0 for one cycle; m0_ack in the 2nd cycle after req; m0_rdata 32'h1234_5678.
- Single write, m1: addr 32'h0020_0010, wdata 32'h41, we 1 → `bus_en` high exactly one cycle with `bus_addr` 32'h0020_0010; m1_ack one cycle later.
- Tie after reset, round-robin: both req high continuously → grant order m0, m1, m0, m1; acks 3 cycles apart. With `IO_ARB_FIXED_PRIO_EN` defined: m0 every 3 cycles, m1 never.
- Keyboard read: addr 32'h0030_0000 → `bus_addr` shows the 12'h003 region for exactly 1 cycle; `bus_addr` = IDLE_ADDR in all IDLE/ACK cycles.
- Reset mid-operation: rst_n low during GNT1 → `bus_en` 0 and m1_ack 0 immediately; after release, state IDLE and m0 wins the next tie.
